fir_sym_tdm: RTL and testbench
==============================

Name: fir_sym_tdm

Overview:
- Parametrised successor to the team's time-multiplexed FIR: symmetric (linear-phase) N_TAPS filter built around one pre-adder and one MAC.
- Adds a valid/ready input handshake, runtime-programmable coefficients, and a rounded, saturated output.
- All logic runs on the system clock; the divided-clock scheme is replaced by clock enables.
- Sits between the input sample register and the downstream output register or consumer.

Parameters:
- WIDTH_DATA, 8, signed input sample width
- WIDTH_COEF, 8, signed coefficient width
- N_TAPS, 16, filter length; must be even and >= 4
- WIDTH_OUT, 8, signed output width
- SHIFT, 7, right shift applied to the accumulator before rounding and saturation; 0..(accumulator width - 1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  din is valid
- in_ready  out  1  block can accept a sample
- din  in  WIDTH_DATA  signed input sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(N_TAPS/2)  coefficient index k
- coef_data  in  WIDTH_COEF  signed coefficient c[k]
- out_valid  out  1  one-cycle pulse; dout holds a new result
- dout  out  WIDTH_OUT  signed filtered sample, held between pulses
- busy  out  1  state != IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Storage:
  - delay line x[0..N_TAPS-1], each WIDTH_DATA signed
  - coefficient RAM c[0..N_TAPS/2-1]
  - impulse response is h[k] = h[N_TAPS-1-k] = c[k]
- Reset values: all x = 0, all c = 0, acc = 0, state IDLE, in_ready = 1, out_valid = 0, dout = 0, busy = 0.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - in_ready = 1 (combinational, equals state==IDLE).
  - Accept at edge E0 when in_valid && in_ready: x[i] <= x[i-1], x[0] <= din, acc <= 0, k <= 0, go to MAC.
  - When in_valid is low, hold state.
- MAC (N_TAPS/2 cycles, edges E0+1..E0+N_TAPS/2):
  - acc += (x[k] + x[N_TAPS-1-k]) * c[k], then k++.
  - Pre-add width is WIDTH_DATA+1; product width is WIDTH_DATA+1+WIDTH_COEF.
  - acc width is the product width + $clog2(N_TAPS/2), so no overflow is possible.
  - Go to OUT after k = N_TAPS/2-1.
- OUT (one cycle): at edge E0+N_TAPS/2+1, return to IDLE and register:
  - r = (acc + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT (arithmetic shift, round half up)
  - dout <= r clamped to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1]
  - out_valid <= 1 for exactly one cycle
- Timing:
  - Latency from the accept edge to out_valid high is N_TAPS/2+1 edges.
  - The earliest next accept is edge E0+N_TAPS/2+2, so throughput is 1 sample per N_TAPS/2+2 cycles (10 for the defaults).
  - in_valid arriving while busy is not consumed; the source must hold it.
- Coefficient writes:
  - coef_we takes effect only in IDLE: c[coef_addr] <= coef_data at that edge.
  - Writes while busy are dropped (no queueing).
  - A write coincident with an accept is applied and used by that same computation.
- Simultaneous events: a write and an accept in the same IDLE cycle are both performed.
- Reset mid-operation: abort the computation at the next edge and return all state to reset values; no out_valid pulse is generated for the aborted sample.

Test Plan:
- Impulse (override SHIFT=0, WIDTH_OUT=16; load c = 1..8): din = 1 then 15 zeros, in_valid held high -> dout sequence 1,2,...,8,8,7,...,1, then 0. One out_valid pulse every 10 cycles, with the first pulse 9 edges after the first accept.
- Rounding (SHIFT=1; c0 = 1, others 0):
  - din = 3 -> dout = 2
  - din = -3 after flushing the line to 0 -> dout = -1
- Saturation (defaults; all c = 127):
  - 16 samples of din = 127 -> dout = 127
  - 16 samples of din = -128 -> dout = -128, with no wrap
- Handshake and busy:
  - in_valid held high -> in_ready low for exactly 9 of every 10 cycles, and exactly 16 samples accepted in 160 cycles.
  - coef_we pulsed while busy=1 -> coefficient unchanged, confirmed by a later impulse response.
- Reset mid-MAC: assert rst at the 4th MAC cycle -> next cycle in_ready = 1, dout = 0, no out_valid. A following impulse with c reloaded to 1..8 reproduces the first scenario exactly.

Source files
------------

// File: rtl/fir_sym_tdm.sv
// Symmetric (linear-phase) time-multiplexed FIR: one pre-adder and one MAC fold the
// N_TAPS-long delay line into N_TAPS/2 products, then round, saturate and register.
module fir_sym_tdm #(
   parameter int WIDTH_DATA = 8,
   parameter int WIDTH_COEF = 8,
   parameter int N_TAPS     = 16,
   parameter int WIDTH_OUT  = 8,
   parameter int SHIFT      = 7
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic signed [WIDTH_DATA-1:0]        din,
   input  logic                                coef_we,
   input  logic        [$clog2(N_TAPS/2)-1:0]  coef_addr,
   input  logic signed [WIDTH_COEF-1:0]        coef_data,
   output logic                                out_valid,
   output logic signed [WIDTH_OUT-1:0]         dout,
   output logic                                busy,
   output logic        [1:0]                   state_dbg
);

   localparam int HALF    = N_TAPS / 2;
   localparam int AW      = $clog2(HALF);
   localparam int XW      = $clog2(N_TAPS);
   localparam int WPRE    = WIDTH_DATA + 1;
   localparam int WPROD   = WPRE + WIDTH_COEF;
   localparam int WACC    = WPROD + $clog2(HALF);
   localparam int WSUM    = WACC + 1;
   localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

   localparam logic        [WSUM-1:0] RND_V = (SHIFT > 0) ? (WSUM'(1) << RND_POS) : '0;
   localparam logic signed [WSUM-1:0] OMAX  = {{(WSUM-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
   localparam logic signed [WSUM-1:0] OMIN  = ~OMAX;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t                        state_q, state_d;
   logic        [AW-1:0]          k_q, k_d;
   logic signed [WACC-1:0]        acc_q, acc_d;
   logic signed [WIDTH_DATA-1:0]  x_q [N_TAPS];
   logic signed [WIDTH_COEF-1:0]  c_q [HALF];
   logic signed [WIDTH_OUT-1:0]   dout_q, dout_d;
   logic                          out_valid_q, out_valid_d;
   logic                          shift_en, coef_wr;

   logic signed [WIDTH_DATA-1:0]  x_near, x_far;
   logic signed [WPRE-1:0]        pre;
   logic signed [WPROD-1:0]       prod;
   logic signed [WSUM-1:0]        sum_r, shr;
   logic signed [WIDTH_OUT-1:0]   sat;

   // Tap k and its mirror N_TAPS-1-k share coefficient c[k], so they are summed first.
   always_comb begin
      x_near = x_q[XW'(k_q)];
      x_far  = x_q[XW'(N_TAPS - 1) - XW'(k_q)];
      pre    = WPRE'(x_near) + WPRE'(x_far);
      prod   = WPROD'(pre) * WPROD'(c_q[k_q]);
      sum_r  = WSUM'(acc_q) + RND_V;
      shr    = sum_r >>> SHIFT;
      if (shr > OMAX) begin
         sat = WIDTH_OUT'(OMAX);
      end else if (shr < OMIN) begin
         sat = WIDTH_OUT'(OMIN);
      end else begin
         sat = WIDTH_OUT'(shr);
      end
   end

   // Input handshake: a sample transfers on a rising edge where in_valid && in_ready;
   // in_ready is high exactly in IDLE and the source holds din/in_valid until then.
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      acc_d       = acc_q;
      dout_d      = dout_q;
      out_valid_d = 1'b0;
      shift_en    = 1'b0;
      coef_wr     = 1'b0;
      case (state_q)
         IDLE: begin
            coef_wr = coef_we;
            if (in_valid) begin
               shift_en = 1'b1;
               acc_d    = '0;
               k_d      = '0;
               state_d  = MAC;
            end
         end
         MAC: begin
            acc_d = acc_q + WACC'(prod);
            k_d   = k_q + AW'(1);
            if (k_q == AW'(HALF - 1)) begin
               state_d = OUT;
            end
         end
         OUT: begin
            dout_d      = sat;
            out_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         k_q         <= '0;
         acc_q       <= '0;
         dout_q      <= '0;
         out_valid_q <= 1'b0;
         for (int i = 0; i < N_TAPS; i++) x_q[i] <= '0;
         for (int i = 0; i < HALF; i++) c_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         acc_q       <= acc_d;
         dout_q      <= dout_d;
         out_valid_q <= out_valid_d;
         if (shift_en) begin
            x_q[0] <= din;
            for (int i = 1; i < N_TAPS; i++) x_q[i] <= x_q[i-1];
         end
         if (coef_wr) begin
            c_q[coef_addr] <= coef_data;
         end
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_fir_sym_tdm.sv
// Bench for fir_sym_tdm: three instances (SHIFT=0/16-bit out, SHIFT=1, defaults) share one
// stimulus stream and are scored against a direct-convolution model of the filter.
module tb_fir_sym_tdm;

   localparam int N = 16;
   localparam int H = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        in_valid = 1'b0;
   logic [7:0]  din = '0;
   logic        coef_we = 1'b0;
   logic [2:0]  coef_addr = '0;
   logic [7:0]  coef_data = '0;

   logic        in_ready_s0, in_ready_s1, in_ready_s7;
   logic        out_valid_s0, out_valid_s1, out_valid_s7;
   logic        busy_s0, busy_s1, busy_s7;
   logic [1:0]  dbg_s0, dbg_s1, dbg_s7;
   logic [15:0] dout_s0;
   logic [7:0]  dout_s1, dout_s7;

   fir_sym_tdm #(.SHIFT(0), .WIDTH_OUT(16)) u_s0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s0), .din(din),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .out_valid(out_valid_s0), .dout(dout_s0), .busy(busy_s0), .state_dbg(dbg_s0));

   fir_sym_tdm #(.SHIFT(1)) u_s1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s1), .din(din),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .out_valid(out_valid_s1), .dout(dout_s1), .busy(busy_s1), .state_dbg(dbg_s1));

   fir_sym_tdm u_s7 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s7), .din(din),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .out_valid(out_valid_s7), .dout(dout_s7), .busy(busy_s7), .state_dbg(dbg_s7));

   // ---------------- checking ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int     x_m [N];
   int     c_m [H];
   int     busy_cnt = 0;
   logic   mon_en = 1'b0;
   longint exp_cyc_q [$];
   logic [15:0] exp_q0 [$];
   logic [7:0]  exp_q1 [$];
   logic [7:0]  exp_q7 [$];
   logic [15:0] held0 = '0;
   logic [7:0]  held1 = '0;
   logic [7:0]  held7 = '0;

   // Direct convolution with h[j] = c[min(j, N-1-j)], then round half up and clamp.
   function automatic longint model_out(input int sh, input int wo);
      longint acc, r, hi, lo;
      acc = 0;
      for (int j = 0; j < N; j++)
         acc += longint'(x_m[j]) * longint'(c_m[(j < H) ? j : N - 1 - j]);
      r  = (sh > 0) ? ((acc + (longint'(1) <<< (sh - 1))) >>> sh) : acc;
      hi = (longint'(1) <<< (wo - 1)) - 1;
      lo = -(longint'(1) <<< (wo - 1));
      if (r > hi) r = hi;
      if (r < lo) r = lo;
      return r;
   endfunction

   task automatic model_reset();
      for (int j = 0; j < N; j++) x_m[j] = 0;
      for (int j = 0; j < H; j++) c_m[j] = 0;
      busy_cnt = 0;
      exp_cyc_q.delete();
      exp_q0.delete();
      exp_q1.delete();
      exp_q7.delete();
      held0 = '0;
      held1 = '0;
      held7 = '0;
   endtask

   // ---------------- scoreboard / monitor ----------------
   logic        cap_on = 1'b0;
   int          cap_n = 0;
   logic [15:0] cap [32];
   longint      cap_cyc [32];
   longint      acc_cyc_q [$];

   always @(negedge clk) begin : mon
      logic rdy_m, hit;
      if (mon_en) begin
         rdy_m = (busy_cnt == 0);
         hit   = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
         if (hit) begin
            void'(exp_cyc_q.pop_front());
            held0 = exp_q0.pop_front();
            held1 = exp_q1.pop_front();
            held7 = exp_q7.pop_front();
         end
         check("in_ready_s0", in_ready_s0, rdy_m);
         check("in_ready_s1", in_ready_s1, rdy_m);
         check("in_ready_s7", in_ready_s7, rdy_m);
         check("busy_s0", busy_s0, !rdy_m);
         check("out_valid_s0", out_valid_s0, hit);
         check("out_valid_s1", out_valid_s1, hit);
         check("out_valid_s7", out_valid_s7, hit);
         check("dout_s0", $signed(dout_s0), $signed(held0));
         check("dout_s1", $signed(dout_s1), $signed(held1));
         check("dout_s7", $signed(dout_s7), $signed(held7));
         if (cap_on && out_valid_s0 && cap_n < 32) begin
            cap[cap_n]     = dout_s0;
            cap_cyc[cap_n] = cyc;
            cap_n++;
         end
         if (in_valid && in_ready_s0 && !rst) acc_cyc_q.push_back(cyc);
         if (busy_cnt > 0) busy_cnt--;
         if (rst) begin
            model_reset();
         end else begin
            if (coef_we && rdy_m) c_m[coef_addr] = int'($signed(coef_data));
            if (in_valid && rdy_m) begin
               for (int j = N - 1; j > 0; j--) x_m[j] = x_m[j-1];
               x_m[0]   = int'($signed(din));
               busy_cnt = 9;
               exp_cyc_q.push_back(cyc + 10);
               exp_q0.push_back(16'(model_out(0, 16)));
               exp_q1.push_back(8'(model_out(1, 8)));
               exp_q7.push_back(8'(model_out(7, 8)));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send(input int d);
      logic got;
      din      = 8'(d);
      in_valid = 1'b1;
      got      = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
         @(negedge clk);
         got = in_ready_s0;
      end
      check("accept_wait", got, 1'b1);
      tick();
   endtask

   task automatic wr_coef(input int k, input int v);
      coef_we   = 1'b1;
      coef_addr = 3'(k);
      coef_data = 8'(v);
      tick();
      coef_we   = 1'b0;
   endtask

   task automatic load_ramp();
      for (int k = 0; k < H; k++) wr_coef(k, k + 1);
   endtask

   task automatic flush();
      for (int i = 0; i < N; i++) send(0);
      idle(12);
   endtask

   function automatic int imp_exp(input int i);
      return (i < H) ? i + 1 : ((i < N) ? N - i : 0);
   endfunction

   // Impulse through ramp coefficients; in_valid held high for the whole burst.
   task automatic impulse_run(input string tag);
      flush();
      acc_cyc_q.delete();
      cap_n  = 0;
      cap_on = 1'b1;
      send(1);
      for (int i = 0; i < N; i++) send(0);
      idle(12);
      cap_on = 1'b0;
      check({tag, "_pulses"}, cap_n, 17);
      check({tag, "_accepts"}, acc_cyc_q.size(), 17);
      for (int i = 0; i < 17 && i < cap_n; i++)
         check({tag, "_dout"}, $signed(cap[i]), imp_exp(i));
      if (cap_n > 0 && acc_cyc_q.size() > 0)
         check({tag, "_first_latency"}, cap_cyc[0] - acc_cyc_q[0], 10);
      for (int i = 1; i < cap_n && i < 17; i++)
         check({tag, "_pulse_spacing"}, cap_cyc[i] - cap_cyc[i-1], 10);
      for (int i = 1; i < acc_cyc_q.size(); i++)
         check({tag, "_accept_spacing"}, acc_cyc_q[i] - acc_cyc_q[i-1], 10);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      model_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst    = 1'b0;
      mon_en = 1'b1;
      idle(3);

      load_ramp();
      impulse_run("impulse1");

      // A coefficient write during MAC must be dropped.
      send(7);
      in_valid = 1'b0;
      tick();
      wr_coef(0, 99);
      idle(12);
      impulse_run("impulse_after_busy_write");

      // Rounding on the SHIFT=1 instance with c0 = 1 only.
      wr_coef(0, 1);
      for (int k = 1; k < H; k++) wr_coef(k, 0);
      flush();
      send(3);
      idle(12);
      check("round_pos", $signed(dout_s1), 2);
      flush();
      send(-3);
      idle(12);
      check("round_neg", $signed(dout_s1), -1);

      // Saturation with all coefficients at +127.
      for (int k = 0; k < H; k++) wr_coef(k, 127);
      for (int i = 0; i < N; i++) send(127);
      idle(12);
      check("sat_pos", $signed(dout_s7), 127);
      for (int i = 0; i < N; i++) send(-128);
      idle(12);
      check("sat_neg", $signed(dout_s7), -128);

      // Reset sampled on the 4th MAC edge aborts the sample.
      send(5);
      in_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready_s0, 1'b1);
      check("rst_dout", $signed(dout_s0), 0);
      check("rst_out_valid", out_valid_s0, 1'b0);
      tick();
      idle(12);
      load_ramp();
      impulse_run("impulse_after_reset");

      // Randomised traffic: gaps, writes at any time (busy or not), occasional reset.
      for (int it = 0; it < 250; it++) begin
         case ($urandom_range(0, 19))
            0, 1, 2, 3, 4, 5, 6, 7, 8, 9: begin
               send(int'($urandom_range(0, 255)) - 128);
               if ($urandom_range(0, 1) == 1) in_valid = 1'b0;
            end
            10, 11, 12, 13: wr_coef(int'($urandom_range(0, H - 1)), int'($urandom_range(0, 255)) - 128);
            14, 15, 16, 17, 18: idle(int'($urandom_range(0, 12)));
            default: begin
               in_valid = 1'b0;
               rst = 1'b1;
               tick();
               rst = 1'b0;
            end
         endcase
      end
      idle(15);
      check("drain_empty", exp_cyc_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #(2_000_000);
      $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
